des_display_pager: RTL and testbench
====================================

// Module: des_display_pager
// PURPOSE
//   Pages a 64-bit DES result (plaintext, ciphertext or key) onto the four-digit
//   hex display, 16 bits at a time. Latches the word on a load strobe, selects one
//   of four 16-bit pages by next/prev buttons or by a timed auto-scroll, and drives
//   the 16-bit value feeding the four-digit hex display driver.
// PARAMETERS
//   PAGE_TICKS  50_000_000  clock cycles per page in auto-scroll (1 s at 50 MHz); >=2
//   CNT_W       26          width of the auto-scroll timer; 2**CNT_W >= PAGE_TICKS
// PORTS
//   clk        in   1   system clock, all state on rising edge
//   rst        in   1   asynchronous active-high reset
//   data_in    in   64  DES result word to display
//   load       in   1   1-cycle strobe: capture data_in
//   clr        in   1   1-cycle strobe: discard word, return to blank display
//   btn_next   in   1   debounced, clk-synchronous level; rising edge = next page
//   btn_prev   in   1   debounced, clk-synchronous level; rising edge = previous page
//   auto_en    in   1   level: 1 = auto-scroll pages, 0 = manual only
//   disp_val   out  16  value to the four-digit hex display driver
//   page_idx   out  2   current page, 0 = bits [63:48] ... 3 = bits [15:0]
//   loaded     out  1   1 while a captured word is held
// BEHAVIOUR
//   - One clock, asynchronous active-high reset on rst.
//   - Reset: state IDLE, data_q=0, page_idx=0, timer=0, disp_val=16'h0000, loaded=0,
//     button edge-detect registers=0 (a button held through reset release does not
//     count as a press).
//   - States: IDLE (nothing loaded), MANUAL, AUTO. loaded=1 in MANUAL and AUTO.
//   - disp_val = data_q[63-16*page_idx -: 16], combinational from registers; shows the
//     new page in the same cycle page_idx changes. In IDLE disp_val=0 (data_q=0).
//   - Priority each cycle: clr > load > button press > auto tick.
//   - clr (any state): -> IDLE, data_q=0, page_idx=0, timer=0.
//   - load (any state, clr low): data_q<=data_in, page_idx<=0, timer<=0;
//     next state AUTO if auto_en else MANUAL. Reload mid-scroll restarts at page 0.
//   - Press = rising edge of btn_next/btn_prev vs. previous-cycle sample; one page per
//     edge regardless of hold length. next: page+1, 3 wraps to 0. prev: page-1, 0 wraps
//     to 3. Both edges same cycle: no page change, no timer clear. Presses in IDLE ignored.
//   - AUTO: timer counts 0..PAGE_TICKS-1; at PAGE_TICKS-1 page_idx<=page_idx+1 (wrap)
//     and timer<=0, so a page lasts exactly PAGE_TICKS cycles. A valid press in AUTO
//     moves the page and clears timer; it stays in AUTO.
//   - MANUAL->AUTO when auto_en rises (timer starts at 0); AUTO->MANUAL when auto_en
//     falls (timer cleared, page held). Timer is held at 0 in IDLE and MANUAL.
//   - auto_en is sampled only in MANUAL/AUTO and at load; in IDLE it has no effect.
// TESTING  (PAGE_TICKS=4)
//   - Reset: rst pulse mid-AUTO -> disp_val=0, page_idx=0, loaded=0 immediately (async).
//   - load data_in=64'h0123_4567_89AB_CDEF, auto_en=0 -> disp_val=16'h0123, loaded=1;
//     3 btn_next edges -> 4567, 89AB, CDEF; 4th -> wraps to 0123; btn_prev from 0 -> CDEF.
//   - btn_next held 10 cycles -> exactly one page advance; next+prev rising same cycle ->
//     page unchanged.
//   - auto_en=1 after load -> page 0,1,2,3,0 each held exactly 4 cycles; press at timer=2
//     -> page advances, next auto step 4 cycles after the press.
//   - load and clr same cycle -> IDLE, disp_val=0; load and btn_next same cycle -> page 0.
//   - IDLE: btn_next edges and auto_en=1 for 20 cycles -> page_idx=0, disp_val=0 throughout.

Source files
------------

// File: rtl/des_display_pager.sv
// des_display_pager
// Holds a 64-bit DES result and pages it onto a four-digit hex display,
// 16 bits at a time. Page selection comes from next/prev button edges or
// from a timed auto-scroll that shows each page for PAGE_TICKS cycles.
module des_display_pager #(
  parameter int PAGE_TICKS = 50_000_000,
  parameter int CNT_W      = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data_in,
  input  logic        load,
  input  logic        clr,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic        auto_en,
  output logic [15:0] disp_val,
  output logic [1:0]  page_idx,
  output logic        loaded
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MANUAL = 2'd1;
  localparam logic [1:0] AUTO   = 2'd2;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(PAGE_TICKS - 1);

  logic [1:0]       state_q, state_d;
  logic [63:0]      data_q, data_d;
  logic [1:0]       page_q, page_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             btnNext_q, btnPrev_q;

  logic nextEdge, prevEdge, pressNext, pressPrev;

  // A press is a rising edge against last cycle's sample; simultaneous
  // edges on both buttons cancel and count as no press at all.
  always_comb begin
    nextEdge  = btn_next & ~btnNext_q;
    prevEdge  = btn_prev & ~btnPrev_q;
    pressNext = nextEdge & ~prevEdge;
    pressPrev = prevEdge & ~nextEdge;
  end

  // Next-state logic, priority clr > load > button press > auto tick.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    page_d  = page_q;
    timer_d = timer_q;
    if (clr) begin
      state_d = IDLE;
      data_d  = 64'd0;
      page_d  = 2'd0;
      timer_d = '0;
    end else if (load) begin
      data_d  = data_in;
      page_d  = 2'd0;
      timer_d = '0;
      state_d = auto_en ? AUTO : MANUAL;
    end else begin
      case (state_q)
        MANUAL: begin
          timer_d = '0;
          if (pressNext) begin
            page_d = page_q + 2'd1;
          end else if (pressPrev) begin
            page_d = page_q - 2'd1;
          end
          if (auto_en) begin
            state_d = AUTO;
          end
        end
        AUTO: begin
          if (pressNext) begin
            page_d  = page_q + 2'd1;
            timer_d = '0;
          end else if (pressPrev) begin
            page_d  = page_q - 2'd1;
            timer_d = '0;
          end else if (timer_q == TICK_LAST) begin
            page_d  = page_q + 2'd1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
          if (!auto_en) begin
            state_d = MANUAL;
            timer_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          data_d  = 64'd0;
          page_d  = 2'd0;
          timer_d = '0;
        end
      endcase
    end
  end

  // State registers; button samples reset low so a button held through
  // reset release is not seen as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= 64'd0;
      page_q    <= 2'd0;
      timer_q   <= '0;
      btnNext_q <= 1'b0;
      btnPrev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      page_q    <= page_d;
      timer_q   <= timer_d;
      btnNext_q <= btn_next;
      btnPrev_q <= btn_prev;
    end
  end

  // Display mux straight from registers so a page change shows at once.
  always_comb begin
    case (page_q)
      2'd0:    disp_val = data_q[63:48];
      2'd1:    disp_val = data_q[47:32];
      2'd2:    disp_val = data_q[31:16];
      default: disp_val = data_q[15:0];
    endcase
  end

  assign page_idx = page_q;
  assign loaded   = (state_q != IDLE);

endmodule

// File: tb/tb_des_display_pager.sv
// tb_des_display_pager
// Directed bench for des_display_pager with PAGE_TICKS=4.
module tb_des_display_pager;

  localparam logic [63:0] WORD = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data_in = 64'd0;
  logic        load = 1'b0, clr = 1'b0, btn_next = 1'b0, btn_prev = 1'b0, auto_en = 1'b0;
  logic [15:0] disp_val;
  logic [1:0]  page_idx;
  logic        loaded;

  int testCount = 0;
  int failCount = 0;

  des_display_pager #(.PAGE_TICKS(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .clr(clr),
    .btn_next(btn_next), .btn_prev(btn_prev), .auto_en(auto_en),
    .disp_val(disp_val), .page_idx(page_idx), .loaded(loaded)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ld, input logic cl, input logic bn,
                               input logic bp, input logic ae, input logic [63:0] din);
    load = ld; clr = cl; btn_next = bn; btn_prev = bp; auto_en = ae; data_in = din;
  endtask

  // Advance n rising edges, leaving time at the following falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Checks page, display value and loaded flag together.
  task automatic checkView(input string tag, input logic [1:0] pg, input logic [15:0] dv, input logic ld);
    checkOutput({tag, ".page"}, 64'(page_idx), 64'(pg));
    checkOutput({tag, ".disp"}, 64'(disp_val), 64'(dv));
    checkOutput({tag, ".loaded"}, 64'(loaded), 64'(ld));
  endtask

  initial begin
    logic [15:0] pages [4];
    pages[0] = 16'h0123; pages[1] = 16'h4567; pages[2] = 16'h89AB; pages[3] = 16'hCDEF;

    // Reset state
    @(negedge clk);
    checkView("reset", 2'd0, 16'h0000, 1'b0);
    rst = 1'b0;
    tick(1);

    // Load in manual mode
    applyStimulus(1, 0, 0, 0, 0, WORD);
    tick(1);
    applyStimulus(0, 0, 0, 0, 0, 64'd0);
    checkView("load", 2'd0, 16'h0123, 1'b1);

    // Four next presses walk the pages and wrap
    for (int p = 1; p <= 4; p++) begin
      applyStimulus(0, 0, 1, 0, 0, 64'd0);
      tick(1);
      checkView("next", 2'(p), pages[p % 4], 1'b1);
      applyStimulus(0, 0, 0, 0, 0, 64'd0);
      tick(1);
    end

    // Prev from page 0 wraps to page 3
    applyStimulus(0, 0, 0, 1, 0, 64'd0);
    tick(1);
    checkView("prevWrap", 2'd3, 16'hCDEF, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 64'd0);
    tick(1);

    // Held button advances exactly once
    applyStimulus(0, 0, 1, 0, 0, 64'd0);
    tick(10);
    checkView("hold", 2'd0, 16'h0123, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 64'd0);
    tick(1);

    // Both edges together leave the page alone
    applyStimulus(0, 0, 1, 1, 0, 64'd0);
    tick(1);
    checkView("both", 2'd0, 16'h0123, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 64'd0);
    tick(1);
    checkView("bothRelease", 2'd0, 16'h0123, 1'b1);

    // Auto-scroll: page k/4 mod 4 after the k-th edge following load
    applyStimulus(1, 0, 0, 0, 1, WORD);
    tick(1);
    applyStimulus(0, 0, 0, 0, 1, 64'd0);
    checkView("autoLoad", 2'd0, 16'h0123, 1'b1);
    for (int k = 1; k <= 18; k++) begin
      tick(1);
      checkOutput("autoPage", 64'(page_idx), 64'((k / 4) % 4));
    end
    checkOutput("autoDisp", 64'(disp_val), 64'h0123);

    // Press with timer at 2 advances now and restarts the 4-cycle page
    applyStimulus(0, 0, 1, 0, 1, 64'd0);
    tick(1);
    checkView("autoPress", 2'd1, 16'h4567, 1'b1);
    applyStimulus(0, 0, 0, 0, 1, 64'd0);
    tick(3);
    checkView("autoHold", 2'd1, 16'h4567, 1'b1);
    tick(1);
    checkView("autoStep", 2'd2, 16'h89AB, 1'b1);

    // Asynchronous reset mid-scroll clears outputs at once
    #2 rst = 1'b1;
    #1 checkView("asyncRst", 2'd0, 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 64'd0);
    tick(1);

    // Load and clr together: clr wins
    applyStimulus(1, 0, 0, 0, 0, WORD);
    tick(1);
    applyStimulus(1, 1, 0, 0, 0, WORD);
    tick(1);
    applyStimulus(0, 0, 0, 0, 0, 64'd0);
    checkView("loadClr", 2'd0, 16'h0000, 1'b0);

    // Load and next together: load wins, page 0
    applyStimulus(1, 0, 0, 0, 0, WORD);
    tick(1);
    applyStimulus(0, 0, 1, 0, 0, 64'd0);
    tick(1);
    applyStimulus(0, 0, 0, 0, 0, 64'd0);
    tick(1);
    checkView("preLoadNext", 2'd1, 16'h4567, 1'b1);
    applyStimulus(1, 0, 1, 0, 0, WORD);
    tick(1);
    applyStimulus(0, 0, 0, 0, 0, 64'd0);
    checkView("loadNext", 2'd0, 16'h0123, 1'b1);

    // IDLE ignores presses and auto_en
    applyStimulus(0, 1, 0, 0, 0, 64'd0);
    tick(1);
    for (int c = 0; c < 20; c++) begin
      applyStimulus(0, 0, c[0], 0, 1, 64'd0);
      tick(1);
      checkView("idle", 2'd0, 16'h0000, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
